// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one synchronous memory port among NREQ requesters,
// with locked bursts capped at MAX_BURST, pipelined read-return routing and saturating perf counters.
module mem_port_arbiter #(
    parameter int NREQ      = 2,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 100
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        lock,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ*ADDR_W-1:0] addr,
    input  logic [NREQ*DATA_W-1:0] wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rvalid,
    output logic [DATA_W-1:0]      rdata,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic                   mem_wren,
    input  logic [DATA_W-1:0]      mem_q,
    output logic                   busy,
    output logic [31:0]            access_count,
    output logic [31:0]            wait_count
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t                    state, state_next;
    logic [NREQ-1:0]           gnt_next;
    logic [IW-1:0]             rr, owner, start, idx;
    logic [BW-1:0]             burst;
    logic                      xfer, last, rel, arb, found;
    logic [31:0]               nwait;
    logic [32:0]               wsum;
    // one-hot requester tag of each read, aged one stage per cycle until its data returns
    logic [RD_LAT:0][NREQ-1:0] pipe;

    always_comb begin
        owner = '0;
        for (int k = 0; k < NREQ; k++) owner = gnt[k] ? IW'(k) : owner;
        xfer  = |(gnt & req);
        last  = burst == BW'(MAX_BURST - 1);
        rel   = (state == OWNED) && (!req[owner] || (xfer && (!lock[owner] || last)));
        arb   = (state == IDLE) || rel;
        start = rel ? ((int'(owner) == NREQ - 1) ? '0 : owner + IW'(1)) : rr;
        gnt_next = arb ? '0 : gnt;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(start) + k) % NREQ);
            if (arb && !found && req[idx]) begin
                gnt_next[idx] = 1'b1;
                found = 1'b1;
            end
        end
        state_next = |gnt_next ? OWNED : IDLE;
        nwait = '0;
        for (int k = 0; k < NREQ; k++) nwait = nwait + 32'(req[k] & ~gnt[k]);
        wsum = {1'b0, wait_count} + {1'b0, nwait};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            gnt          <= '0;
            rr           <= '0;
            burst        <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wren     <= 1'b0;
            pipe         <= '0;
            access_count <= '0;
            wait_count   <= '0;
        end else begin
            state <= state_next;
            gnt   <= gnt_next;
            burst <= arb ? '0 : burst + BW'(xfer);
            if (rel) rr <= start;
            if (xfer) begin
                mem_addr  <= addr[int'(owner)*ADDR_W +: ADDR_W];
                mem_wdata <= wdata[int'(owner)*DATA_W +: DATA_W];
            end
            mem_wren <= xfer & we[owner];
            pipe     <= {pipe[RD_LAT-1:0], gnt & req & ~we};
            if (xfer && access_count != '1) access_count <= access_count + 32'd1;
            wait_count <= wsum[32] ? '1 : wsum[31:0];
        end
    end

    assign rvalid = pipe[RD_LAT];
    assign rdata  = |rvalid ? mem_q : '0;
    assign busy   = |gnt || |pipe;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized requester traffic checked every cycle
// against a transaction-level model of the arbitration, burst and read-return rules.
module tb_mem_port_arbiter;
    localparam int N = 2, AW = 19, DW = 8, RL = 1, MB = 100;

    typedef struct {
        int            due;
        int            who;
        logic [DW-1:0] d;
    } rd_t;

    logic              clk = 1'b0, rst = 1'b1;
    logic [N-1:0]      req = '0, lock = '0, we = '0;
    logic [N*AW-1:0]   addr = '0;
    logic [N*DW-1:0]   wdata = '0;
    logic [N-1:0]      gnt, rvalid;
    logic [DW-1:0]     rdata, mem_wdata, mem_q;
    logic [AW-1:0]     mem_addr;
    logic              mem_wren, busy;
    logic [31:0]       access_count, wait_count;
    logic [DW-1:0]     ram [1024];

    mem_port_arbiter #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wren(mem_wren), .mem_q(mem_q), .busy(busy), .access_count(access_count),
        .wait_count(wait_count)
    );

    always #10 clk = ~clk;

    // single-cycle-latency synchronous RAM on the shared port
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr[9:0]] <= mem_wdata;
        mem_q <= ram[mem_addr[9:0]];
    end

    int            m_own, m_rr, m_burst, cyc, n_chk, n_pass;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_wren;
    longint        m_acc, m_wait;
    rd_t           rq[$];
    logic [DW-1:0] m_mem [1024];
    int            rem[N], done[N], abort_at[N];
    logic [AW-1:0] base[N];
    logic [DW-1:0] jdat[N];
    logic          jlock[N], jwe[N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_reset();
        m_own = -1; m_rr = 0; m_burst = 0;
        m_addr = '0; m_wdata = '0; m_wren = 1'b0;
        m_acc = 0; m_wait = 0;
        rq.delete();
    endtask

    task automatic pick(input int from);
        m_own = -1;
        m_burst = 0;
        for (int k = 0; k < N; k++)
            if (m_own < 0 && req[(from + k) % N]) m_own = (from + k) % N;
    endtask

    task automatic compare();
        logic [N-1:0]  eg, erv;
        logic [DW-1:0] erd;
        logic          eb;
        eg = '0;
        if (m_own >= 0) eg[m_own] = 1'b1;
        eb = (m_own >= 0) || (rq.size() > 0);
        erv = '0;
        erd = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            erv[rq[0].who] = 1'b1;
            erd = rq[0].d;
            void'(rq.pop_front());
        end
        check("gnt", 64'(gnt), 64'(eg));
        check("rvalid", 64'(rvalid), 64'(erv));
        check("rdata", 64'(rdata), 64'(erd));
        check("mem_addr", 64'(mem_addr), 64'(m_addr));
        check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        check("mem_wren", 64'(mem_wren), 64'(m_wren));
        check("busy", 64'(busy), 64'(eb));
        check("access_count", 64'(access_count), 64'(m_acc));
        check("wait_count", 64'(wait_count), 64'(m_wait));
    endtask

    task automatic advance();
        bit x;
        int a;
        x = (m_own >= 0) && req[m_own];
        for (int i = 0; i < N; i++) if (req[i] && m_own != i) m_wait++;
        if (m_wait > 64'hFFFF_FFFF) m_wait = 64'hFFFF_FFFF;
        m_wren = 1'b0;
        if (x) begin
            m_addr  = addr[m_own*AW +: AW];
            m_wdata = wdata[m_own*DW +: DW];
            m_wren  = we[m_own];
            a = int'(m_addr[9:0]);
            if (we[m_own]) m_mem[a] = m_wdata;
            else rq.push_back('{cyc + 1 + RL, m_own, m_mem[a]});
            if (m_acc < 64'hFFFF_FFFF) m_acc++;
            m_burst++;
        end
        if (m_own < 0) pick(m_rr);
        else if (!req[m_own] || (x && (!lock[m_own] || m_burst == MB))) begin
            m_rr = (m_own + 1) % N;
            pick(m_rr);
        end
    endtask

    task automatic new_job(input int i, input int len, input bit lk, input bit w,
                           input logic [AW-1:0] b, input logic [DW-1:0] d, input int ab);
        rem[i] = len; done[i] = 0; abort_at[i] = ab;
        jlock[i] = lk; jwe[i] = w; base[i] = b; jdat[i] = d;
    endtask

    task automatic drive(input bit rnd);
        for (int i = 0; i < N; i++) begin
            if (rem[i] > 0 && abort_at[i] == done[i]) rem[i] = 0;
            if (rnd && rem[i] == 0 && $urandom_range(3) == 0)
                new_job(i, ($urandom_range(19) == 0) ? $urandom_range(101, 130) : $urandom_range(1, 8),
                        1'($urandom_range(1)), 1'($urandom_range(1)), AW'($urandom_range(1023)),
                        DW'($urandom), ($urandom_range(5) == 0) ? $urandom_range(0, 3) : -1);
            req[i]  = rem[i] > 0;
            lock[i] = (rem[i] == 0) ? 1'($urandom_range(1)) : (rem[i] > 1) && jlock[i];
            we[i]   = jwe[i];
            addr[i*AW +: AW]  = base[i] + AW'(done[i]);
            wdata[i*DW +: DW] = jdat[i] ^ DW'(done[i] * 37);
        end
    endtask

    task automatic cycle(input bit rnd);
        drive(rnd);
        @(negedge clk);
        compare();
        for (int i = 0; i < N; i++) if (req[i] && gnt[i]) begin done[i]++; rem[i]--; end
        advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) rem[i] = 0;
        req = '0; lock = '0; we = '0;
        model_reset();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
    endtask

    task automatic run_idle(input int maxc);
        int  c;
        bit  pend;
        c = 0;
        pend = 1'b1;
        while (pend && c < maxc) begin
            pend = (m_own >= 0) || (rq.size() > 0);
            for (int i = 0; i < N; i++) if (rem[i] > 0) pend = 1'b1;
            if (pend) begin cycle(0); c++; end
        end
        check("idle_reached", 64'(!pend), 64'(1));
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) begin
            ram[k]   = DW'(k * 7 + 3);
            m_mem[k] = DW'(k * 7 + 3);
        end
        for (int i = 0; i < N; i++) new_job(i, 0, 1'b0, 1'b0, '0, '0, -1);
        cyc = 0; n_chk = 0; n_pass = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        new_job(0, 100, 1'b1, 1'b0, 19'd0, 8'd0, -1);
        run_idle(300);
        check("burst_access", 64'(access_count), 64'd100);
        do_reset();
        new_job(0, 2, 1'b0, 1'b0, 19'd200, 8'd0, -1);
        new_job(1, 2, 1'b0, 1'b0, 19'd300, 8'd0, -1);
        run_idle(50);
        check("rotate_access", 64'(access_count), 64'd4);
        new_job(0, 150, 1'b1, 1'b0, 19'd400, 8'd0, -1);
        cycle(0);
        cycle(0);
        new_job(1, 5, 1'b1, 1'b0, 19'd600, 8'd0, -1);
        run_idle(400);
        new_job(1, 1, 1'b0, 1'b1, 19'h00010, 8'hA5, -1);
        run_idle(20);
        new_job(0, 20, 1'b1, 1'b0, 19'd700, 8'd0, 5);
        new_job(1, 3, 1'b0, 1'b0, 19'd800, 8'd0, -1);
        run_idle(100);
        new_job(0, 10, 1'b1, 1'b0, 19'd900, 8'd0, -1);
        repeat (4) cycle(0);
        do_reset();
        new_job(0, 2, 1'b0, 1'b0, 19'd100, 8'd0, -1);
        new_job(1, 2, 1'b0, 1'b0, 19'd150, 8'd0, -1);
        run_idle(50);
        repeat (4000) cycle(1);
        run_idle(500);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
